// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM capture block.
// Holds the CSR word addresses (decoded from address[2:0]), the CTRL and
// STATUS bit positions and the measurement FSM state encoding.
package pwm_pkg;

  // CSR word addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_HIGH    = 3'd3;
  localparam logic [2:0] ADDR_DIVISOR = 3'd4;

  // CTRL bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_ONE_SHOT = 2;

  // STATUS bit positions (valid/overflow are write-one-to-clear, level is read-only)
  localparam int STAT_VALID    = 0;
  localparam int STAT_OVERFLOW = 1;
  localparam int STAT_LEVEL    = 2;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: brings the asynchronous PWM pin into the clk domain through a
// SYNC_STAGES-deep flop chain, then compares against one extra flop to find
// edges.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   pwm_in - asynchronous PWM pin
//   level  - synchronised pin level (registered)
//   rise   - one-cycle pulse on a synchronised 0->1 transition
//   fall   - one-cycle pulse on a synchronised 1->0 transition
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser chain plus the edge-detect history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign fall  = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM signal in
// prescaled ticks and exposes the results on a 16-bit CSR bus.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   chipselect   - bus block select
//   write_enable - write strobe (qualified by chipselect)
//   read_enable  - read strobe (qualified by chipselect)
//   address      - word address, bits [2:0] decoded
//   writedata    - write data
//   readdata     - registered read data, one cycle after the read strobe
//   pwm_in       - asynchronous PWM input
//   irq          - level interrupt: irq_en & (valid | overflow), registered
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [15:0] address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        pwm_in,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // CSR state
  logic             enable_r;
  logic             irq_en_r;
  logic             one_shot_r;
  logic             valid_r;
  logic             overflow_r;
  logic [CNT_W-1:0] divisor_r;
  logic [CNT_W-1:0] period_cap_r;
  logic [CNT_W-1:0] high_cap_r;
  logic [15:0]      readdata_r;
  logic             irq_r;

  // Measurement state
  cap_state_e       state_r;
  cap_state_e       state_nxt_s;
  logic [CNT_W-1:0] presc_cnt_r;
  logic [CNT_W-1:0] period_cnt_r;
  logic [CNT_W-1:0] high_cnt_r;
  logic [CNT_W-1:0] period_nxt_s;
  logic [CNT_W-1:0] high_nxt_s;
  logic             capture_s;
  logic             ovf_set_s;
  logic             oneshot_clr_s;
  logic             tick_s;

  // Bus decode
  logic             wr_s;
  logic             rd_s;
  logic [2:0]       addr_s;
  logic [15:0]      rd_mux_s;

  // Input path
  logic             level_s;
  logic             rise_s;
  logic             fall_s;
  logic             unused_s;

  pwm_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (reset),
    .pwm_in (pwm_in),
    .level  (level_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // Period is rise-to-rise, so the falling edge carries no information here.
  assign unused_s = ^{fall_s, address[15:3], writedata[15:3]};

  assign wr_s   = chipselect & write_enable;
  assign rd_s   = chipselect & read_enable;
  assign addr_s = address[2:0];
  assign tick_s = (presc_cnt_r == divisor_r);

  // Prescaler: counts 0..DIVISOR, restarting from 0 whenever the FSM idles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt_r <= '0;
    end else if (state_r == ST_IDLE) begin
      presc_cnt_r <= '0;
    end else if (tick_s) begin
      presc_cnt_r <= '0;
    end else begin
      presc_cnt_r <= presc_cnt_r + CNT_ONE;
    end
  end

  // FSM state and measurement counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      period_cnt_r <= '0;
      high_cnt_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      period_cnt_r <= period_nxt_s;
      high_cnt_r   <= high_nxt_s;
    end
  end

  // Next-state and counter logic; a detected rise takes precedence over the
  // overflow check so a full-scale period is still captured.
  always_comb begin
    state_nxt_s   = state_r;
    period_nxt_s  = period_cnt_r;
    high_nxt_s    = high_cnt_r;
    capture_s     = 1'b0;
    ovf_set_s     = 1'b0;
    oneshot_clr_s = 1'b0;
    if (!enable_r) begin
      state_nxt_s  = ST_IDLE;
      period_nxt_s = '0;
      high_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s  = ST_ARM;
          period_nxt_s = '0;
          high_nxt_s   = '0;
        end
        ST_ARM: begin
          if (rise_s) begin
            state_nxt_s  = ST_MEASURE;
            period_nxt_s = tick_s ? CNT_ONE : '0;
            high_nxt_s   = tick_s ? CNT_ONE : '0;
          end else begin
            period_nxt_s = '0;
            high_nxt_s   = '0;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            capture_s    = 1'b1;
            period_nxt_s = tick_s ? CNT_ONE : '0;
            high_nxt_s   = tick_s ? CNT_ONE : '0;
            if (one_shot_r) begin
              state_nxt_s   = ST_IDLE;
              oneshot_clr_s = 1'b1;
            end else begin
              state_nxt_s   = ST_MEASURE;
            end
          end else if (tick_s) begin
            if (period_cnt_r == CNT_MAX) begin
              // Constant input: give up on this period and re-arm
              ovf_set_s    = 1'b1;
              period_nxt_s = '0;
              high_nxt_s   = '0;
              state_nxt_s  = ST_ARM;
            end else begin
              period_nxt_s = period_cnt_r + CNT_ONE;
              if (level_s) begin
                high_nxt_s = high_cnt_r + CNT_ONE;
              end else begin
                high_nxt_s = high_cnt_r;
              end
            end
          end else begin
            period_nxt_s = period_cnt_r;
            high_nxt_s   = high_cnt_r;
          end
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          period_nxt_s = '0;
          high_nxt_s   = '0;
        end
      endcase
    end
  end

  // CTRL register; a bus write wins over the one-shot auto-clear of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_r   <= 1'b0;
      irq_en_r   <= 1'b0;
      one_shot_r <= 1'b0;
    end else if (wr_s && (addr_s == ADDR_CTRL)) begin
      enable_r   <= writedata[CTRL_ENABLE];
      irq_en_r   <= writedata[CTRL_IRQ_EN];
      one_shot_r <= writedata[CTRL_ONE_SHOT];
    end else if (oneshot_clr_s) begin
      enable_r   <= 1'b0;
    end else begin
      enable_r   <= enable_r;
    end
  end

  // STATUS flags: hardware set beats a same-cycle write-one-to-clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      valid_r    <= capture_s |
                    (valid_r & ~(wr_s && (addr_s == ADDR_STATUS) && writedata[STAT_VALID]));
      overflow_r <= ovf_set_s |
                    (overflow_r & ~(wr_s && (addr_s == ADDR_STATUS) && writedata[STAT_OVERFLOW]));
    end
  end

  // DIVISOR register; the new value is used from the next tick compare
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divisor_r <= '0;
    end else if (wr_s && (addr_s == ADDR_DIVISOR)) begin
      divisor_r <= writedata[CNT_W-1:0];
    end else begin
      divisor_r <= divisor_r;
    end
  end

  // Capture registers, loaded on each measured rise-to-rise interval
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cap_r <= '0;
      high_cap_r   <= '0;
    end else if (capture_s) begin
      period_cap_r <= period_cnt_r;
      high_cap_r   <= high_cnt_r;
    end else begin
      period_cap_r <= period_cap_r;
      high_cap_r   <= high_cap_r;
    end
  end

  // Read mux; unused bits and addresses 5-7 return zero
  always_comb begin
    rd_mux_s = 16'h0000;
    case (addr_s)
      ADDR_CTRL: begin
        rd_mux_s[CTRL_ENABLE]   = enable_r;
        rd_mux_s[CTRL_IRQ_EN]   = irq_en_r;
        rd_mux_s[CTRL_ONE_SHOT] = one_shot_r;
      end
      ADDR_STATUS: begin
        rd_mux_s[STAT_VALID]    = valid_r;
        rd_mux_s[STAT_OVERFLOW] = overflow_r;
        rd_mux_s[STAT_LEVEL]    = level_s;
      end
      ADDR_PERIOD:  rd_mux_s[CNT_W-1:0] = period_cap_r;
      ADDR_HIGH:    rd_mux_s[CNT_W-1:0] = high_cap_r;
      ADDR_DIVISOR: rd_mux_s[CNT_W-1:0] = divisor_r;
      default:      rd_mux_s = 16'h0000;
    endcase
  end

  // Registered read data; holds between reads. A same-edge capture is not
  // visible until the following read because the mux sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_r <= 16'h0000;
    end else if (rd_s) begin
      readdata_r <= rd_mux_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  // Registered interrupt, one cycle behind the status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en_r & (valid_r | overflow_r);
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule
